stream_mux_rr: RTL and testbench

STREAM_MUX_RR -- requirements
Module: stream_mux_rr

---
 rtl/stream_mux_rr.sv | 141 ++++++++++++++
 tb/tb_stream_mux_rr.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// Round-robin N_CH-to-1 stream multiplexer feeding a one-entry registered output stage.
// Define STREAM_MUX_RR_LAST_LOCK_EN to add in_last/out_last and keep the grant for a whole packet.
module stream_mux_rr #(
    parameter int N_CH = 4,
    parameter int W    = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_CH-1:0]         in_valid,
    input  logic [N_CH*W-1:0]       in_data,
    output logic [N_CH-1:0]         in_ready,
`ifdef STREAM_MUX_RR_LAST_LOCK_EN
    input  logic [N_CH-1:0]         in_last,
    output logic                    out_last,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [W-1:0]            out_data,
    output logic [$clog2(N_CH)-1:0] out_ch
);
    localparam int PW = $clog2(N_CH);

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_next;
    logic            load_en;
    logic [N_CH-1:0] eligible;
    logic [PW-1:0]   gnt_idx;
    logic            gnt_any;
    logic [N_CH-1:0] gnt_oh;
    logic            xfer;
    logic [W-1:0]    gnt_data;

    assign load_en = !out_valid || out_ready;

`ifdef STREAM_MUX_RR_LAST_LOCK_EN
    logic          locked;
    logic [PW-1:0] lock_ch;
    logic          gnt_last;

    // While a packet is in flight only the locked channel may compete.
    always_comb begin
        eligible = in_valid;
        if (locked) begin
            eligible          = '0;
            eligible[lock_ch] = in_valid[lock_ch];
        end
    end

    assign gnt_last = |(gnt_oh & in_last);
`else
    assign eligible = in_valid;
`endif

    // Channels at or above ptr beat those below it; within each half the lowest index wins.
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (eligible[i] && (PW'(i) < ptr)) begin
                gnt_idx = PW'(i);
                gnt_any = 1'b1;
            end
        end
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (eligible[i] && (PW'(i) >= ptr)) begin
                gnt_idx = PW'(i);
                gnt_any = 1'b1;
            end
        end
    end

    always_comb begin
        gnt_oh = '0;
        for (int i = 0; i < N_CH; i++) begin
            gnt_oh[i] = rst_n && load_en && gnt_any && (gnt_idx == PW'(i));
        end
    end

    assign in_ready = gnt_oh;
    assign xfer     = |gnt_oh;

    // AND-OR select so unknown data on losing channels cannot leak into the result.
    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            gnt_data = gnt_data | (in_data[i*W +: W] & {W{gnt_oh[i]}});
        end
    end

    assign ptr_next = (gnt_idx == PW'(N_CH - 1)) ? '0 : gnt_idx + PW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else if (load_en) begin
            out_valid <= xfer;
            if (xfer) begin
                out_data <= gnt_data;
                out_ch   <= gnt_idx;
            end
        end
    end

`ifdef STREAM_MUX_RR_LAST_LOCK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_last <= 1'b0;
        end else if (load_en && xfer) begin
            out_last <= gnt_last;
        end
    end

    // Rotation only advances once a packet's final beat has been taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= '0;
            locked  <= 1'b0;
            lock_ch <= '0;
        end else if (xfer) begin
            if (gnt_last) begin
                locked <= 1'b0;
                ptr    <= ptr_next;
            end else begin
                locked  <= 1'b1;
                lock_ch <= gnt_idx;
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (xfer) begin
            ptr <= ptr_next;
        end
    end
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr: directed scenarios plus randomized traffic against a queue-free
// behavioural model (held beat, rotation pointer, packet lock) compared every cycle.
module tb_stream_mux_rr;
    localparam int N_CH = 4;
    localparam int W    = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  in_valid;
    logic [15:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_data;
    logic [1:0]  out_ch;
`ifdef STREAM_MUX_RR_LAST_LOCK_EN
    logic [3:0]  in_last;
    logic        out_last;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit running = 1'b1;

    always #5 clk = ~clk;

    stream_mux_rr #(.N_CH(N_CH), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
`ifdef STREAM_MUX_RR_LAST_LOCK_EN
        .in_last   (in_last),
        .out_last  (out_last),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch)
    );

    // Reference model state: the beat the output register should hold and the rotation origin.
    bit         m_valid = 1'b0;
    logic [3:0] m_data  = '0;
    int         m_ch    = 0;
    int         m_ptr   = 0;
`ifdef STREAM_MUX_RR_LAST_LOCK_EN
    bit         m_last    = 1'b0;
    bit         m_lock    = 1'b0;
    int         m_lock_ch = 0;
`endif
    int         exp_gnt;
    logic [3:0] exp_rdy;

    always_comb begin
        exp_gnt = -1;
        if (rst_n === 1'b1 && !(m_valid && !out_ready)) begin
            for (int k = N_CH - 1; k >= 0; k--) begin
                int c;
                bit req;
                c   = (m_ptr + k) % N_CH;
                req = ((in_valid >> c) & 4'b0001) != 4'b0000;
`ifdef STREAM_MUX_RR_LAST_LOCK_EN
                if (m_lock && c != m_lock_ch) req = 1'b0;
`endif
                if (req) exp_gnt = c;
            end
        end
        exp_rdy = (exp_gnt >= 0) ? (4'b0001 << exp_gnt) : 4'b0000;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_ch    <= 0;
            m_ptr   <= 0;
`ifdef STREAM_MUX_RR_LAST_LOCK_EN
            m_last  <= 1'b0;
            m_lock  <= 1'b0;
`endif
        end else if (exp_gnt >= 0) begin
            m_valid <= 1'b1;
            m_data  <= W'(in_data >> (exp_gnt * W));
            m_ch    <= exp_gnt;
`ifdef STREAM_MUX_RR_LAST_LOCK_EN
            m_last  <= ((in_last >> exp_gnt) & 4'b0001) != 4'b0000;
            if (((in_last >> exp_gnt) & 4'b0001) != 4'b0000) begin
                m_lock <= 1'b0;
                m_ptr  <= (exp_gnt + 1) % N_CH;
            end else begin
                m_lock    <= 1'b1;
                m_lock_ch <= exp_gnt;
            end
`else
            m_ptr   <= (exp_gnt + 1) % N_CH;
`endif
        end else if (out_ready) begin
            m_valid <= 1'b0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (running) begin
            checkOutput("model_in_ready", in_ready, exp_rdy);
            checkOutput("model_out_valid", out_valid, m_valid);
            if (m_valid) begin
                checkOutput("model_out_data", out_data, m_data);
                checkOutput("model_out_ch", out_ch, m_ch);
`ifdef STREAM_MUX_RR_LAST_LOCK_EN
                checkOutput("model_out_last", out_last, m_last);
`endif
            end
        end
    end

    task automatic applyStimulus(input logic [3:0] v, input logic [15:0] d, input logic r);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
`ifdef STREAM_MUX_RR_LAST_LOCK_EN
        in_last   = '0;
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int exp3[3];
        logic [15:0] d;
        logic [3:0]  v;
        exp3 = '{1, 3, 1};
        rst_n     = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
`ifdef STREAM_MUX_RR_LAST_LOCK_EN
        in_last   = '0;
`endif
        #1 rst_n = 1'b0;
        in_valid = 4'b1111;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_in_ready", in_ready, 4'b0000);
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_out_data", out_data, 4'h0);
        checkOutput("rst_out_ch", out_ch, 2'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = '0;

        // Reset while a beat is held, then a lone request on channel 2.
        applyStimulus(4'b1000, 16'h7000, 1'b0);
        applyStimulus(4'b0000, 16'h0000, 1'b0);
        #1;
        checkOutput("s1_held_valid", out_valid, 1'b1);
        checkOutput("s1_held_ch", out_ch, 2'd3);
        checkOutput("s1_held_data", out_data, 4'h7);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("s1_async_valid", out_valid, 1'b0);
        checkOutput("s1_async_ch", out_ch, 2'd0);
        checkOutput("s1_async_data", out_data, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(4'b0100, 16'h0900, 1'b1);
        #1;
        checkOutput("s1_grant", in_ready, 4'b0100);
        checkOutput("s1_no_stale", out_valid, 1'b0);
        applyStimulus(4'b0000, 16'h0000, 1'b1);
        #1;
        checkOutput("s1_out_valid", out_valid, 1'b1);
        checkOutput("s1_out_ch", out_ch, 2'd2);
        checkOutput("s1_out_data", out_data, 4'h9);

        // Full rotation with every channel requesting.
        doReset();
        for (int k = 0; k < 5; k++) begin
            applyStimulus(4'b1111, 16'hDCBA, 1'b1);
            #1;
            checkOutput("s2_in_ready", in_ready, 32'(1 << (k % 4)));
            if (k > 0) begin
                checkOutput("s2_out_ch", out_ch, 32'((k - 1) % 4));
                checkOutput("s2_out_data", out_data, 32'(10 + (k - 1) % 4));
            end
        end
        applyStimulus(4'b0000, 16'h0000, 1'b1);
        #1;
        checkOutput("s2_last_valid", out_valid, 1'b1);
        checkOutput("s2_last_ch", out_ch, 2'd0);
        checkOutput("s2_last_data", out_data, 4'hA);

        // Sparse requests on channels 1 and 3.
        doReset();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'b1010, 16'h3010, 1'b1);
            #1;
            checkOutput("s3_in_ready", in_ready, 32'(1 << exp3[k]));
            if (k > 0) checkOutput("s3_out_ch", out_ch, 32'(exp3[k-1]));
        end

        // Backpressure on a held beat of 5.
        doReset();
        applyStimulus(4'b0001, 16'h0005, 1'b0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'b0010, 16'h0060, 1'b0);
            #1;
            checkOutput("s4_hold_data", out_data, 4'h5);
            checkOutput("s4_hold_valid", out_valid, 1'b1);
            checkOutput("s4_hold_ready", in_ready, 4'b0000);
        end
        applyStimulus(4'b0010, 16'h0060, 1'b1);
        #1;
        checkOutput("s4_drain_load", in_ready, 4'b0010);
        applyStimulus(4'b0000, 16'h0000, 1'b1);
        #1;
        checkOutput("s4_next_valid", out_valid, 1'b1);
        checkOutput("s4_next_data", out_data, 4'h6);
        checkOutput("s4_next_ch", out_ch, 2'd1);
        applyStimulus(4'b0000, 16'h0000, 1'b1);
        #1;
        checkOutput("s4_empty", out_valid, 1'b0);

        // Idle cycles with the pointer at 2.
        doReset();
        applyStimulus(4'b0010, 16'h0070, 1'b1);
        applyStimulus(4'b0000, 16'h0000, 1'b1);
        #1;
        checkOutput("s5_model_ptr", m_ptr, 2);
        checkOutput("s5_idle_ready0", in_ready, 4'b0000);
        checkOutput("s5_draining", out_valid, 1'b1);
        applyStimulus(4'b0000, 16'h0000, 1'b1);
        #1;
        checkOutput("s5_idle_ready1", in_ready, 4'b0000);
        checkOutput("s5_drained", out_valid, 1'b0);
        applyStimulus(4'b1111, 16'h4321, 1'b1);
        #1;
        checkOutput("s5_ptr_kept", in_ready, 4'b0100);

`ifdef STREAM_MUX_RR_LAST_LOCK_EN
        // Three-beat packet on channel 0 while channel 1 keeps requesting.
        doReset();
        in_last = 4'b0010;
        applyStimulus(4'b0011, 16'h0081, 1'b1);
        #1;
        checkOutput("s6_beat1_rdy", in_ready, 4'b0001);
        applyStimulus(4'b0011, 16'h0082, 1'b1);
        #1;
        checkOutput("s6_beat2_rdy", in_ready, 4'b0001);
        checkOutput("s6_out1_last", out_last, 1'b0);
        in_last = 4'b0011;
        applyStimulus(4'b0011, 16'h0083, 1'b1);
        #1;
        checkOutput("s6_beat3_rdy", in_ready, 4'b0001);
        checkOutput("s6_out2_ch", out_ch, 2'd0);
        checkOutput("s6_out2_last", out_last, 1'b0);
        in_last = 4'b0010;
        applyStimulus(4'b0010, 16'h0080, 1'b1);
        #1;
        checkOutput("s6_ch1_rdy", in_ready, 4'b0010);
        checkOutput("s6_out3_data", out_data, 4'h3);
        checkOutput("s6_out3_last", out_last, 1'b1);
        applyStimulus(4'b0000, 16'h0000, 1'b1);
        #1;
        checkOutput("s6_out4_ch", out_ch, 2'd1);
        checkOutput("s6_out4_data", out_data, 4'h8);
`endif

        // Randomized traffic; losing channels carry unknown data.
        doReset();
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                doReset();
            end else begin
                v = 4'($urandom_range(0, 15));
                for (int c = 0; c < N_CH; c++) begin
                    if (v[c]) d[c*W +: W] = 4'($urandom_range(0, 15));
                    else      d[c*W +: W] = 4'bxxxx;
                end
`ifdef STREAM_MUX_RR_LAST_LOCK_EN
                in_last = 4'($urandom_range(0, 15));
`endif
                applyStimulus(v, d, $urandom_range(0, 3) != 0);
            end
        end

        @(negedge clk);
        #3;
        running = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
